mult_arb_sched: RTL and testbench
=================================

MULT_ARB_SCHED -- requirements
Module: mult_arb_sched

Interface
REQ-001 Parameter data_width_in1, default 25, SHALL set the width of each requester's A operand.
REQ-002 Parameter data_width_in2, default 18, SHALL set the width of each requester's B operand.
REQ-003 Parameter NUM_REQ, default 4, SHALL set the number of requesters; legal range 2..8.
REQ-004 Parameter PIPE_STAGES, default 2, SHALL set the accept-to-result latency in cycles; legal range 1..4.
REQ-005 Local OUT_W = data_width_in1 + data_width_in2 and ID_W = clog2(NUM_REQ).
REQ-006 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-007 RST  input  1  reset, synchronous, active-high.
REQ-008 req_valid  input  NUM_REQ  bit i high: requester i presents an operand pair.
REQ-009 req_ready  output  NUM_REQ  one-hot-or-zero grant; bit i high: requester i's pair is accepted this cycle.
REQ-010 req_a  input  NUM_REQ*data_width_in1  packed A operands, requester i at slice [i*data_width_in1 +: data_width_in1].
REQ-011 req_b  input  NUM_REQ*data_width_in2  packed B operands, requester i at slice [i*data_width_in2 +: data_width_in2].
REQ-012 hold  input  1  high: no new grants are issued, and in-flight operations continue to drain.
REQ-013 out_valid  output  1  high for one cycle per completed product.
REQ-014 out_product  output  OUT_W  unsigned product A*B.
REQ-015 out_id  output  ID_W  index of the requester that owns out_product.
REQ-016 busy  output  1  high while any pipeline stage holds a valid operation.

Function
REQ-017 Acceptance SHALL occur for requester i in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-018 req_ready SHALL be combinational from req_valid, hold and the round-robin pointer, with at most one bit high.
REQ-019 req_ready SHALL be all-zero when hold is high or when req_valid is all-zero.
REQ-020 Arbitration: search starts at pointer index p, ascends with wrap NUM_REQ-1 -> 0, and the first requester with valid high is granted.
REQ-021 On a grant to index g, the pointer SHALL become (g+1) mod NUM_REQ; without a grant, the pointer SHALL hold.
REQ-022 A lone valid requester SHALL be granted every cycle (throughput 1 operation per cycle; no bubbles inserted).
REQ-023 req_ready SHALL NOT depend on out_valid; the result path has no backpressure.
REQ-024 Pipeline: stage 1 registers the granted A, B and id plus a valid bit; later stages carry the product, id and valid; the multiply is full-width unsigned with no truncation.
REQ-025 Latency: a pair accepted in cycle t SHALL produce out_valid=1 in cycle t+PIPE_STAGES, with matching out_product and out_id.
REQ-026 Ordering: results SHALL emerge in acceptance order, one per accepted pair, and none are dropped or duplicated.
REQ-027 When out_valid=0, out_product and out_id SHALL hold their last values.
REQ-028 busy SHALL be the OR of all stage valid bits and SHALL be combinational from registered state.
REQ-029 Changes to req_valid or operands while the corresponding ready is low SHALL have no effect on the pipeline.

Reset
REQ-030 When RST=1 at a clock edge, all stage valid bits, out_valid, out_product, out_id and the pointer SHALL clear to 0.
REQ-031 While RST=1, req_ready SHALL be all-zero.
REQ-032 Reset mid-operation SHALL discard all in-flight operations, and no out_valid SHALL follow for pairs accepted before reset.
REQ-033 The first cycle after RST deasserts SHALL be able to grant, with pointer=0.

Verification
REQ-034 Reset, then req_valid=0001, a=3, b=5 for one cycle -> req_ready=0001 in that cycle; with PIPE_STAGES=2, out_valid=1, out_product=15, out_id=0 two cycles later.
REQ-035 All four valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; out_id follows the same sequence PIPE_STAGES cycles later, and out_valid stays high continuously.
REQ-036 a=0x1FFFFFF, b=0x3FFFF -> out_product=0x7FFFDFC0001 (43 bits), with no truncation.
REQ-037 hold=1 for 3 cycles while req_valid=1111 -> req_ready=0000 in those cycles, already-accepted results still emerge, and after hold falls, grants resume from the held pointer.
REQ-038 Accept 2 pairs, then RST=1 one cycle later -> no out_valid for either pair, busy=0 after the reset edge, and the next grant goes to index 0.
REQ-039 Repeat REQ-034 for PIPE_STAGES=1 and 4 -> out_valid at t+1 and t+4 respectively.

Source files
------------

// File: rtl/mult_arb_sched.sv
// Round-robin arbiter in front of a pipelined unsigned multiplier.
// Ports: CLK/RST, req_valid/req_ready/req_a/req_b, hold, out_valid/out_product/out_id, busy.
module mult_arb_sched #(
  parameter int data_width_in1 = 25,
  parameter int data_width_in2 = 18,
  parameter int NUM_REQ = 4,
  parameter int PIPE_STAGES = 2,
  localparam int OUT_W = data_width_in1 + data_width_in2,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*data_width_in1-1:0] req_a,
  input  logic [NUM_REQ*data_width_in2-1:0] req_b,
  input  logic                             hold,
  output logic                             out_valid,
  output logic [OUT_W-1:0]                 out_product,
  output logic [ID_W-1:0]                  out_id,
  output logic                             busy
);

  // Product stages after stage 1; with one stage the product
  // is formed before the only register.
  localparam int NP = (PIPE_STAGES == 1) ? 1 : PIPE_STAGES - 1;

  logic [ID_W-1:0]           ptr;
  logic [ID_W-1:0]           gnt_id;
  logic                      gnt;
  logic [data_width_in1-1:0] gnt_a;
  logic [data_width_in2-1:0] gnt_b;

  always_comb begin
    int idx;
    idx = 0;
    gnt = 1'b0;
    gnt_id = '0;
    if (!RST && !hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!gnt && req_valid[idx]) begin
          gnt = 1'b1;
          gnt_id = ID_W'(idx);
        end
      end
    end
  end

  assign req_ready = gnt ? (NUM_REQ'(1) << gnt_id) : '0;

  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        gnt_a = req_a[i*data_width_in1 +: data_width_in1];
        gnt_b = req_b[i*data_width_in2 +: data_width_in2];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= '0;
    end else if (gnt) begin
      if (int'(gnt_id) == NUM_REQ - 1) ptr <= '0;
      else ptr <= gnt_id + ID_W'(1);
    end
  end

  logic             src_v;
  logic [OUT_W-1:0] src_prod;
  logic [ID_W-1:0]  src_id;
  logic             s1_busy;

  generate
    if (PIPE_STAGES == 1) begin : g_p1
      assign src_v = gnt;
      assign src_id = gnt_id;
      assign src_prod = OUT_W'(gnt_a) * OUT_W'(gnt_b);
      assign s1_busy = 1'b0;
    end else begin : g_pn
      logic                      s1_v;
      logic [data_width_in1-1:0] s1_a;
      logic [data_width_in2-1:0] s1_b;
      logic [ID_W-1:0]           s1_id;

      always_ff @(posedge CLK) begin
        if (RST) s1_v <= 1'b0;
        else s1_v <= gnt;
        if (gnt) begin
          s1_a <= gnt_a;
          s1_b <= gnt_b;
          s1_id <= gnt_id;
        end
      end

      assign src_v = s1_v;
      assign src_id = s1_id;
      assign src_prod = OUT_W'(s1_a) * OUT_W'(s1_b);
      assign s1_busy = s1_v;
    end
  endgenerate

  logic [NP-1:0]    pv;
  logic [OUT_W-1:0] pp  [NP];
  logic [ID_W-1:0]  pid [NP];

  // Data only moves with a valid bit, so the last stage
  // holds its previous result while idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pv <= '0;
      for (int i = 0; i < NP; i++) begin
        pp[i] <= '0;
        pid[i] <= '0;
      end
    end else begin
      pv[0] <= src_v;
      if (src_v) begin
        pp[0] <= src_prod;
        pid[0] <= src_id;
      end
      for (int i = 1; i < NP; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pp[i] <= pp[i-1];
          pid[i] <= pid[i-1];
        end
      end
    end
  end

  assign out_valid = pv[NP-1];
  assign out_product = pp[NP-1];
  assign out_id = pid[NP-1];
  assign busy = s1_busy | (|pv);

endmodule

// File: tb/tb_mult_arb_sched.sv
// Bench: three instances (1, 2 and 4 stages) on shared stimulus,
// checked against a cycle-indexed history model.
module tb_mult_arb_sched;

  localparam int N = 4;
  localparam int W1 = 25;
  localparam int W2 = 18;
  localparam int OW = W1 + W2;
  localparam int HN = 8192;

  logic            clk = 1'b0;
  logic            RST;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N*W1-1:0] req_a;
  logic [N*W2-1:0] req_b;

  logic [N-1:0]  rdy   [3];
  logic          out_v [3];
  logic [OW-1:0] out_p [3];
  logic [1:0]    out_i [3];
  logic          bsy   [3];

  int pk [3] = '{1, 2, 4};

  int errs = 0;
  int checks = 0;
  bit run = 0;

  always #5 clk = ~clk;

  mult_arb_sched #(.PIPE_STAGES(1)) d1 (
    .CLK(clk), .RST(RST), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_a(req_a), .req_b(req_b), .hold(hold), .out_valid(out_v[0]),
    .out_product(out_p[0]), .out_id(out_i[0]), .busy(bsy[0]));

  mult_arb_sched #(.PIPE_STAGES(2)) d2 (
    .CLK(clk), .RST(RST), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_a(req_a), .req_b(req_b), .hold(hold), .out_valid(out_v[1]),
    .out_product(out_p[1]), .out_id(out_i[1]), .busy(bsy[1]));

  mult_arb_sched #(.PIPE_STAGES(4)) d4 (
    .CLK(clk), .RST(RST), .req_valid(req_valid), .req_ready(rdy[2]),
    .req_a(req_a), .req_b(req_b), .hold(hold), .out_valid(out_v[2]),
    .out_product(out_p[2]), .out_id(out_i[2]), .busy(bsy[2]));

  task automatic chk(input string name, input longint unsigned got,
                     input longint unsigned exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model history, indexed by cycle number.
  bit              hv    [HN];
  int              hid   [HN];
  longint unsigned hprod [HN];
  bit              hrst  [HN];
  int              cyc = 0;
  int              mptr = 0;
  bit              mv [3];
  longint unsigned mp [3];
  int              mi [3];

  function automatic bit rst_in(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) if (hrst[r]) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin : cmp
    int g, idx, c, p, lo;
    bit ov, bz;
    longint unsigned av, bv;
    if (run) begin
      c = cyc;
      g = -1;
      if (!RST && !hold)
        for (int k = 0; k < N; k++) begin
          idx = (mptr + k) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      hv[c] = (g >= 0);
      hid[c] = g;
      hrst[c] = RST;
      hprod[c] = 0;
      if (g >= 0) begin
        av = longint'(req_a[g*W1 +: W1]);
        bv = longint'(req_b[g*W2 +: W2]);
        hprod[c] = av * bv;
      end
      for (int k = 0; k < 3; k++)
        chk($sformatf("ready_p%0d", pk[k]), longint'(rdy[k]),
            (g >= 0) ? (64'd1 << g) : 64'd0);
      if (c >= 1) begin
        for (int k = 0; k < 3; k++) begin
          p = pk[k];
          if (hrst[c-1]) begin
            mv[k] = 0; mp[k] = 0; mi[k] = 0;
          end else begin
            ov = (c - p >= 0) && hv[c-p] && !rst_in(c - p, c - 1);
            mv[k] = ov;
            if (ov) begin
              mp[k] = hprod[c-p];
              mi[k] = hid[c-p];
            end
          end
          lo = (c - p < 0) ? 0 : c - p;
          bz = 0;
          for (int r = lo; r <= c - 1; r++)
            if (hv[r] && !rst_in(r, c - 1)) bz = 1;
          chk($sformatf("out_valid_p%0d", p), longint'(out_v[k]), longint'(mv[k]));
          chk($sformatf("out_product_p%0d", p), longint'(out_p[k]), mp[k]);
          chk($sformatf("out_id_p%0d", p), longint'(out_i[k]), longint'(mi[k]));
          chk($sformatf("busy_p%0d", p), longint'(bsy[k]), longint'(bz));
        end
      end
      if (RST) mptr = 0;
      else if (g >= 0) mptr = (g + 1) % N;
      cyc++;
    end
  end

  task automatic tick(input logic r, input logic h, input logic [N-1:0] v);
    @(posedge clk);
    #1;
    RST = r;
    hold = h;
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        req_a[i*W1 +: W1] = '1;
        req_b[i*W2 +: W2] = '1;
      end else begin
        req_a[i*W1 +: W1] = W1'($urandom);
        req_b[i*W2 +: W2] = W2'($urandom);
      end
    end
  endtask

  initial begin
    logic [N-1:0] v;
    RST = 1'b1;
    hold = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    run = 1;
    tick(1, 0, 4'b0000);

    // Single pair 3*5 seen at each latency.
    tick(0, 0, 4'b0001);
    req_a[0 +: W1] = 25'd3;
    req_b[0 +: W2] = 18'd5;
    @(negedge clk);
    chk("lit_ready_first", longint'(rdy[1]), 64'h1);
    tick(0, 0, 4'b0000);
    @(negedge clk);
    chk("lit_p1_valid", longint'(out_v[0]), 64'd1);
    chk("lit_p1_prod", longint'(out_p[0]), 64'd15);
    tick(0, 0, 4'b0000);
    @(negedge clk);
    chk("lit_p2_valid", longint'(out_v[1]), 64'd1);
    chk("lit_p2_prod", longint'(out_p[1]), 64'd15);
    chk("lit_p2_id", longint'(out_i[1]), 64'd0);
    tick(0, 0, 4'b0000);
    tick(0, 0, 4'b0000);
    @(negedge clk);
    chk("lit_p4_valid", longint'(out_v[2]), 64'd1);
    chk("lit_p4_prod", longint'(out_p[2]), 64'd15);

    // Round-robin order from pointer 0.
    tick(1, 0, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 4'b1111);
      @(negedge clk);
      chk("lit_rr_order", longint'(rdy[1]), 64'd1 << (i % 4));
    end

    // Full-width product.
    tick(0, 0, 4'b0001);
    req_a[0 +: W1] = 25'h1FFFFFF;
    req_b[0 +: W2] = 18'h3FFFF;
    tick(0, 0, 4'b0000);
    tick(0, 0, 4'b0000);
    @(negedge clk);
    chk("lit_max_prod", longint'(out_p[1]), 64'h7FFFDFC0001);

    // Hold blocks grants; pointer resumes where it was.
    tick(0, 0, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 4'b1111);
      @(negedge clk);
      chk("lit_hold_ready", longint'(rdy[1]), 64'd0);
    end
    tick(0, 0, 4'b1111);
    @(negedge clk);
    chk("lit_hold_resume", longint'(rdy[1]), 64'h4);

    // Reset discards in-flight work.
    tick(0, 0, 4'b1111);
    tick(0, 0, 4'b1111);
    tick(1, 0, 4'b1111);
    tick(0, 0, 4'b1111);
    @(negedge clk);
    chk("lit_rst_ready", longint'(rdy[1]), 64'h1);
    chk("lit_rst_busy_p2", longint'(bsy[1]), 64'd0);
    chk("lit_rst_busy_p4", longint'(bsy[2]), 64'd0);

    for (int n = 0; n < 1500; n++) begin
      v = N'($urandom);
      if ($urandom_range(0, 3) == 0) v = N'(1) << $urandom_range(0, N - 1);
      tick(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 10), v);
    end

    for (int n = 0; n < 6; n++) tick(0, 0, 4'b0000);
    @(negedge clk);
    #1;
    run = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
